// File: rtl/asmd_pkg.sv
// asmd_pkg: constants and state encodings shared by the ASMD multiplier and divider blocks.
//   MULT_*      : multiplier word length and step count
//   DIV_*       : divider default word length
//   div_state_t : divider controller state encoding (IDLE, RUN)
package asmd_pkg;

   // Multiplier constants
   localparam int unsigned MULT_WORD_LENGTH = 4;
   localparam int unsigned MULT_STEPS       = MULT_WORD_LENGTH;

   // Divider constants
   localparam int unsigned DIV_WORD_LENGTH  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } div_state_t;

endpackage : asmd_pkg

// File: rtl/asmd_div_datapath.sv
// asmd_div_datapath: restoring-division datapath (working remainder R, shift register Q,
// captured divisor, compare-subtract, result and flag registers).
//   clk, rst          : clock, async active-high reset
//   i_load            : request accepted this edge (capture operands / error result)
//   i_step            : perform one restoring step this edge
//   i_done            : last step; load quotient/remainder from the step result
//   i_dividend        : 2W-bit unsigned dividend
//   i_divisor         : W-bit unsigned divisor
//   o_err_c           : combinational; current operands are divide-by-zero or overflow
//   o_quotient        : registered quotient
//   o_remainder       : registered remainder
//   o_div_by_zero     : registered flag
//   o_overflow        : registered flag
module asmd_div_datapath
   import asmd_pkg::*;
#(
   parameter int unsigned W = DIV_WORD_LENGTH
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_load,
   input  logic           i_step,
   input  logic           i_done,
   input  logic [2*W-1:0] i_dividend,
   input  logic [W-1:0]   i_divisor,
   output logic           o_err_c,
   output logic [W-1:0]   o_quotient,
   output logic [W-1:0]   o_remainder,
   output logic           o_div_by_zero,
   output logic           o_overflow
);

   logic [W:0]   r_r;
   logic [W-1:0] r_q;
   logic [W-1:0] r_d;

   logic         w_dz;
   logic         w_ovf;
   logic [W+1:0] w_r_sh;
   logic [W+1:0] w_diff;
   logic         w_ge;
   logic [W:0]   w_r_nxt;
   logic [W-1:0] w_q_nxt;

   // Error classification on the live operands; divide-by-zero takes priority
   always_comb begin
      w_dz    = (i_divisor == '0);
      w_ovf   = !w_dz && (i_dividend[2*W-1:W] >= i_divisor);
      o_err_c = w_dz | w_ovf;
   end

   // One restoring step: shift {R,Q} left, trial-subtract, keep on no borrow
   always_comb begin
      w_r_sh  = {r_r, r_q[W-1]};
      w_diff  = w_r_sh - {2'b00, r_d};
      w_ge    = !w_diff[W+1];
      w_r_nxt = w_ge ? w_diff[W:0] : w_r_sh[W:0];
      w_q_nxt = r_q << 1;
      w_q_nxt[0] = w_ge;
   end

   // Working and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_r           <= '0;
         r_q           <= '0;
         r_d           <= '0;
         o_quotient    <= '0;
         o_remainder   <= '0;
         o_div_by_zero <= 1'b0;
         o_overflow    <= 1'b0;
      end else if (i_load) begin
         r_d           <= i_divisor;
         o_div_by_zero <= w_dz;
         o_overflow    <= w_ovf;
         if (w_dz || w_ovf) begin
            o_quotient  <= '1;
            o_remainder <= i_dividend[W-1:0];
         end else begin
            r_r <= {1'b0, i_dividend[2*W-1:W]};
            r_q <= i_dividend[W-1:0];
         end
      end else if (i_step) begin
         r_r <= w_r_nxt;
         r_q <= w_q_nxt;
         if (i_done) begin
            o_quotient  <= w_q_nxt;
            o_remainder <= w_r_nxt[W-1:0];
         end
      end
   end

endmodule : asmd_div_datapath

// File: rtl/asmd_divider.sv
// asmd_divider: sequential restoring divider, 2W-bit dividend by W-bit divisor,
// W RUN cycles per non-error request.
//   clk, reset  : clock, async active-high reset
//   start       : level request, sampled in IDLE
//   dividend    : 2W-bit unsigned dividend
//   divisor     : W-bit unsigned divisor
//   quotient    : W-bit result
//   remainder   : W-bit result
//   ready       : high in IDLE
//   div_by_zero : last accepted request had divisor == 0
//   overflow    : last accepted request had quotient wider than W bits
module asmd_divider
   import asmd_pkg::*;
#(
   parameter int unsigned word_length = DIV_WORD_LENGTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [2*word_length-1:0] dividend,
   input  logic [word_length-1:0]   divisor,
   output logic [word_length-1:0]   quotient,
   output logic [word_length-1:0]   remainder,
   output logic                     ready,
   output logic                     div_by_zero,
   output logic                     overflow
);

   localparam int unsigned W  = word_length;
   localparam int unsigned CW = $clog2(W + 1);

   div_state_t    r_state;
   div_state_t    w_state_nxt;
   logic [CW-1:0] r_count;
   logic          r_ready;
   logic          w_load;
   logic          w_step;
   logic          w_done;
   logic          w_err;

   // State, ready and step counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_ready <= 1'b1;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == IDLE);
         if (w_load)
            r_count <= '0;
         else if (w_step)
            r_count <= r_count + CW'(1);
      end
   end

   // Next-state and datapath controls
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load = 1'b1;
               // Error requests complete in IDLE without a RUN phase
               if (!w_err)
                  w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (r_count == CW'(W - 1)) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign ready = r_ready;

   asmd_div_datapath #(
      .W (W)
   ) u_datapath (
      .clk           (clk),
      .rst           (reset),
      .i_load        (w_load),
      .i_step        (w_step),
      .i_done        (w_done),
      .i_dividend    (dividend),
      .i_divisor     (divisor),
      .o_err_c       (w_err),
      .o_quotient    (quotient),
      .o_remainder   (remainder),
      .o_div_by_zero (div_by_zero),
      .o_overflow    (overflow)
   );

endmodule : asmd_divider

// File: tb/tb_asmd_divider.sv
// tb_asmd_divider: directed and randomized checks of asmd_divider (W=4) against
// an arithmetic reference (integer / and %, error rules on the high dividend half).
module tb_asmd_divider;

   localparam int unsigned W = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [2*W-1:0] dividend;
   logic [W-1:0]   divisor;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic           ready;
   logic           div_by_zero;
   logic           overflow;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   asmd_divider #(
      .word_length (W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .ready       (ready),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Issue one single-cycle request and check it against the arithmetic reference.
   // Entered and left at posedge+1.
   task automatic do_op(input logic [7:0] dd, input logic [3:0] dv, input string tag);
      int         idd, idv, exp_q, exp_r, n;
      logic       exp_dz, exp_ov;
      logic [3:0] prev_q, prev_r;
      idd    = int'(dd);
      idv    = int'(dv);
      exp_dz = (idv == 0);
      exp_ov = !exp_dz && ((idd / 16) >= idv);
      if (exp_dz || exp_ov) begin
         exp_q = 15;
         exp_r = idd % 16;
      end else begin
         exp_q = idd / idv;
         exp_r = idd % idv;
      end
      prev_q   = quotient;
      prev_r   = remainder;
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      // Operand changes after acceptance must not matter
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      if (exp_dz || exp_ov) begin
         check({tag, "_err_ready"}, 32'(ready), 32'd1);
      end else begin
         n = 0;
         while (ready !== 1'b1 && n < 3 * W) begin
            check({tag, "_hold"}, 32'({quotient, remainder, div_by_zero, overflow}),
                  32'({prev_q, prev_r, 2'b00}));
            @(posedge clk); #1;
            n++;
         end
         check({tag, "_latency"}, 32'(n), 32'(W));
      end
      check({tag, "_q"},  32'(quotient),    32'(exp_q));
      check({tag, "_r"},  32'(remainder),   32'(exp_r));
      check({tag, "_dz"}, 32'(div_by_zero), 32'(exp_dz));
      check({tag, "_ov"}, 32'(overflow),    32'(exp_ov));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_q",     32'(quotient), 32'd0);
      check("rst_r",     32'(remainder), 32'd0);
      check("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Basic divide 27 / 5
      do_op(8'h1B, 4'd5, "basic");
      check("basic_q_const", 32'(quotient), 32'd5);
      check("basic_r_const", 32'(remainder), 32'd2);

      // Start held high: two back-to-back 0x20 / 3 operations
      dividend = 8'h20;
      divisor  = 4'd3;
      start    = 1'b1;
      @(posedge clk); #1;
      check("held_run1", 32'(ready), 32'd0);
      repeat (3) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      check("held_done1", 32'(ready), 32'd1);
      check("held_q1", 32'(quotient), 32'd10);
      check("held_r1", 32'(remainder), 32'd2);
      @(posedge clk); #1;
      check("held_run2", 32'(ready), 32'd0);
      #4;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      check("held_done2", 32'(ready), 32'd1);
      check("held_q2", 32'(quotient), 32'd10);
      check("held_r2", 32'(remainder), 32'd2);
      @(posedge clk); #1;
      check("held_idle", 32'(ready), 32'd1);

      // Divide by zero and overflow
      do_op(8'h37, 4'd0, "dz");
      check("dz_const", 32'({quotient, remainder}), 32'h0F7);
      do_op(8'h50, 4'd5, "ov");
      check("ov_const", 32'({quotient, remainder, div_by_zero, overflow}), 32'b1111_0000_01);
      do_op(8'h1B, 4'd5, "clear");

      // Reset during the second RUN cycle
      dividend = 8'h4F;
      divisor  = 4'd9;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      #3 reset = 1'b1;
      #1;
      check("mid_rst_ready", 32'(ready), 32'd1);
      check("mid_rst_out", 32'({quotient, remainder, div_by_zero, overflow}), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      do_op(8'h4F, 4'd9, "after_rst");
      check("after_rst_const", 32'({quotient, remainder}), 32'h87);

      // Exhaustive non-error pairs
      for (int dv = 1; dv < 16; dv++) begin
         for (int dd = 0; dd < 256; dd++) begin
            if ((dd / 16) < dv) begin
               do_op(8'(dd), 4'(dv), "exh");
               check("exh_ident", 32'(int'(quotient) * dv + int'(remainder)), 32'(dd));
               check("exh_rem_lt", 32'(int'(remainder) < dv), 32'd1);
            end
         end
      end

      // Randomized mix including error cases
      for (int i = 0; i < 300; i++) begin
         logic [7:0] rdd;
         logic [3:0] rdv;
         rdd = 8'($urandom);
         rdv = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
         do_op(rdd, rdv, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_asmd_divider
